// File: rtl/innerproduct_stream_if.sv
// Stream-side bundle for innerproduct_stream: theta write port, feature
// input stream and result output stream. The block uses the slave side.
interface innerproduct_stream_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6
);
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic              w_busy;

  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              s_last;

  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_err;

  modport master (
    output w_we, w_addr, w_data,
    input  w_busy,
    output s_valid, s_data, s_last,
    input  s_ready,
    input  m_valid, m_data, m_err,
    output m_ready
  );

  modport slave (
    input  w_we, w_addr, w_data,
    output w_busy,
    input  s_valid, s_data, s_last,
    output s_ready,
    output m_valid, m_data, m_err,
    input  m_ready
  );
endinterface

// File: rtl/innerproduct_stream.sv
// Streaming inner product: one feature per beat, h' = THETA0 + sum x[i]*theta[i]
// (i >= 1, modulo 2^DATA_W), with a runtime-writable theta register file and a
// valid/ready result port carrying a framing-error flag.
module innerproduct_stream #(
  parameter int                DATA_W    = 32,
  parameter int                N_FEAT    = 41,
  parameter int                ADDR_W    = 6,
  parameter logic [N_FEAT-1:0] SKIP_MASK = '0
) (
  input logic                   clk,
  input logic                   rst_n,
  innerproduct_stream_if.slave  bus
);

  localparam int IDX_W = $clog2(N_FEAT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    OUT   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nx;
  logic [IDX_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] r_m_data;
  logic              r_m_err;
  logic              r_alive;
  logic [DATA_W-1:0] r_theta [N_FEAT];

  logic              w_s_ready;
  logic              w_busy_o;
  logic              w_m_valid;
  logic              w_fire;
  logic              w_last_idx;
  logic              w_skip;
  logic [DATA_W-1:0] w_theta;
  logic [DATA_W-1:0] w_term;
  logic [DATA_W-1:0] w_sum;

  // Unsigned product, keeping only the low DATA_W bits.
  function automatic logic [DATA_W-1:0] mul_trunc(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
    return DATA_W'(a * b);
  endfunction

  assign w_last_idx = (r_idx == IDX_W'(N_FEAT - 1));

  // Select theta and skip bit for the current feature index.
  always_comb begin
    w_theta = '0;
    w_skip  = 1'b0;
    for (int k = 0; k < N_FEAT; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_theta = r_theta[k];
        w_skip  = SKIP_MASK[k];
      end
    end
    w_term = w_skip ? '0 : mul_trunc(bus.s_data, w_theta);
    w_sum  = r_acc + w_term;
  end

  // Holds s_ready low until the first clock edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_alive <= 1'b0;
    else        r_alive <= 1'b1;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nx;
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_state_nx = r_state;
    w_s_ready  = 1'b0;
    w_busy_o   = 1'b1;
    w_m_valid  = 1'b0;
    w_fire     = 1'b0;
    case (r_state)
      IDLE: begin
        w_s_ready = r_alive;
        w_busy_o  = 1'b0;
        w_fire    = bus.s_valid && r_alive;
        if (w_fire) w_state_nx = bus.s_last ? OUT : ACCUM;
      end
      ACCUM: begin
        w_s_ready = r_alive;
        w_fire    = bus.s_valid && r_alive;
        if (w_fire && (bus.s_last || w_last_idx)) w_state_nx = OUT;
      end
      OUT: begin
        w_m_valid = 1'b1;
        if (bus.m_ready) w_state_nx = IDLE;
      end
      default: w_state_nx = IDLE;
    endcase
  end

  // Theta register file; writable only while idle, out-of-range writes drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_FEAT; k++) r_theta[k] <= '0;
    end else if (bus.w_we && (r_state == IDLE)) begin
      for (int k = 0; k < N_FEAT; k++) begin
        if (bus.w_addr == ADDR_W'(k)) r_theta[k] <= bus.w_data;
      end
    end
  end

  // Accumulator, feature index and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx    <= '0;
      r_acc    <= '0;
      r_m_data <= '0;
      r_m_err  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_fire) begin
            // Bias slot: x[0] is consumed but only THETA0 enters the sum.
            r_acc <= r_theta[0];
            r_idx <= IDX_W'(1);
            if (bus.s_last) begin
              r_m_data <= r_theta[0];
              r_m_err  <= 1'b1;
            end
          end
        end
        ACCUM: begin
          if (w_fire) begin
            r_acc <= w_sum;
            r_idx <= r_idx + IDX_W'(1);
            if (bus.s_last || w_last_idx) begin
              r_m_data <= w_sum;
              r_m_err  <= (bus.s_last != w_last_idx);
            end
          end
        end
        OUT: begin
          if (bus.m_ready) r_idx <= '0;
        end
        default: r_idx <= '0;
      endcase
    end
  end

  assign bus.s_ready = w_s_ready;
  assign bus.w_busy  = w_busy_o;
  assign bus.m_valid = w_m_valid;
  assign bus.m_data  = r_m_data;
  assign bus.m_err   = r_m_err;

endmodule

// File: doc/innerproduct_stream.md
Name: innerproduct_stream

Overview:
- Sequential, parametrised successor to the fully-combinational per-classifier inner-product blocks in the linebuffer logistic-regression datapath.
- Consumes one feature per cycle over a valid/ready stream and accumulates h' = THETA0 + sum over i=1..N_FEAT-1 of x[i]*THETA[i].
- Theta values live in a runtime-writable register file instead of a compile-time header.
- Feeds the sigmoid/threshold stage through a valid/ready result port. One instance per classifier replaces the fixed-width, fixed-depth combinational versions.

Parameters:
- DATA_W, 32: width of features, thetas, products and accumulator; all arithmetic is modulo 2^DATA_W.
- N_FEAT, 41: features per vector including index 0. Index 0 carries the bias slot, so x[0] is consumed but never multiplied. Legal range 2..1024.
- ADDR_W, 6: theta write address width; must satisfy 2^ADDR_W >= N_FEAT.
- SKIP_MASK, {N_FEAT{1'b0}}: bit i=1 forces the product term for feature i to 0. The feature beat is still consumed. Bit 0 is ignored.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- w_we  in  1  theta write strobe.
- w_addr  in  ADDR_W  theta index; 0 writes THETA0 (bias).
- w_data  in  DATA_W  theta value.
- w_busy  out  1  high when not IDLE; theta writes are ignored while high.
- s_valid  in  1  feature beat valid.
- s_ready  out  1  block accepts a feature beat.
- s_data  in  DATA_W  feature x[idx].
- s_last  in  1  marks the final beat of the vector.
- m_valid  out  1  result valid.
- m_ready  in  1  downstream accepts the result.
- m_data  out  DATA_W  accumulated h'.
- m_err  out  1  framing error qualifier, valid with m_valid.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, idx=0, acc=0.
  - All thetas cleared to 0.
  - s_ready=0 during reset.
  - m_valid=0, m_data=0, m_err=0, w_busy=0.
- Release from reset is synchronous to clk. s_ready=1 on the first cycle after rst_n rises.
- Handshake: a beat transfers on a rising edge with s_valid&s_ready. The result transfers with m_valid&m_ready. m_data and m_err are stable while m_valid=1 and m_ready=0.
- FSM states: IDLE, ACCUM, OUT.
  - IDLE:
    - s_ready=1, w_busy=0.
    - On w_we with w_addr<N_FEAT, theta[w_addr]<=w_data. Writes with w_addr>=N_FEAT are dropped.
    - On the first beat: acc<=THETA0, idx<=1, go to ACCUM.
    - If that first beat has s_last=1, it is an early end: go directly to OUT with m_data=THETA0 and m_err=1.
    - If w_we and a first beat arrive in the same cycle, the write completes. The bias latched into acc is the pre-write THETA0.
  - ACCUM:
    - s_ready=1, w_busy=1.
    - Each beat: acc<=acc + (SKIP_MASK[idx] ? 0 : low DATA_W bits of s_data*theta[idx]); idx<=idx+1.
    - Terminating beat is the first beat with s_last=1 or idx=N_FEAT-1.
      - On it, the accumulated sum including that beat loads m_data and state goes to OUT.
      - m_err=1 when s_last differs from (idx==N_FEAT-1).
    - An early s_last stops with a partial sum. A missing s_last at idx=N_FEAT-1 still terminates; any following beats start the next vector.
    - w_we is ignored in ACCUM.
  - OUT:
    - m_valid=1, s_ready=0, w_busy=1.
    - On m_ready: m_valid<=0, idx<=0, go to IDLE.
    - There is no bypass from OUT to the next vector.
- Latency:
  - m_valid rises on the clock edge that accepts the terminating beat, so it is visible in the cycle after the transfer.
  - Minimum period is N_FEAT+1 cycles per vector with m_ready held high.
- Multiply: unsigned, single-cycle combinational multiplier, truncated to DATA_W. No pipelining inside the block.
- s_valid gaps: acc and idx hold.
- Asserting rst_n low mid-vector discards the partial sum and clears the thetas, which must be reloaded afterwards.

Test Plan:
Test configuration: N_FEAT=4, DATA_W=16, SKIP_MASK=4'b0010. Load thetas {5,7,3,2}.
1. Stream x={9,100,4,6}, s_last on beat 3, m_ready=1 → m_data=5+0+12+12=29, m_err=0, m_valid exactly one cycle after beat 3.
2. Same vector with m_ready low for 5 cycles → m_valid and m_data=29 held; s_ready=0 throughout; next vector accepted the cycle after m_ready.
3. s_last on beat 1 (x={1,1}) → m_data=5, m_err=1. A following full vector {0,0,1,1} → m_data=10, m_err=0.
4. Write theta[2]=0x8000 while in ACCUM → ignored, w_busy=1. The same write in IDLE takes effect: x={0,0,4,0} gives m_data=5+0x20000 truncated=5.
5. Random s_valid gaps (~50%) over 100 vectors → results match the reference model with modulo-2^16 wrap, e.g. x[3]=0xFFFF, theta3=2 contributes 0xFFFE.
6. Assert rst_n low mid-ACCUM → outputs and thetas are 0 immediately (async). After release, an unloaded vector {1,2,3,4} gives m_data=0.
